// File: rtl/math_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Kogge-Stone adder.
package math_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Number of prefix levels needed to cover n bits; a 1-bit adder needs none.
  function automatic int ks_levels(input int n);
    int l;
    l = 0;
    while ((1 << l) < n) l++;
    return l;
  endfunction

  function automatic int ks_groups(input int levels, input int pipe_every);
    int g;
    g = (levels + pipe_every - 1) / pipe_every;
    return (g < 1) ? 1 : g;
  endfunction

endpackage

// File: rtl/math_kogge_stone_prefix_level.sv
// One combinational Kogge-Stone prefix level: merges each bit with the bit DIST below it.
module math_kogge_stone_prefix_level
  import math_pkg::*;
#(
  parameter int N    = 32,
  parameter int DIST = 1
) (
  input  gp_t [N-1:0] gp,
  output gp_t [N-1:0] gp_next
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    if (i >= DIST) begin : g_merge
      assign gp_next[i].g = gp[i].g | (gp[i].p & gp[i-DIST].g);
      assign gp_next[i].p = gp[i].p & gp[i-DIST].p;
    end else begin : g_pass
      assign gp_next[i] = gp[i];
    end
  end

endmodule

// File: rtl/math_adder_kogge_stone_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with carry-in, signed overflow, tag sideband
// and valid/ready flow control under a single global stall.
module math_adder_kogge_stone_pipe
  import math_pkg::*;
#(
  parameter int N          = 32,
  parameter int PIPE_EVERY = 2,
  parameter int TAG_W      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N-1:0]     i_a,
  input  logic [N-1:0]     i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N-1:0]     o_sum,
  output logic             o_carry,
  output logic             o_overflow,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  localparam int LEVELS = ks_levels(N);
  localparam int GROUPS = ks_groups(LEVELS, PIPE_EVERY);
  localparam int LAST   = GROUPS - 1;

  logic advance;
  assign advance = !o_valid || i_ready;
  assign o_ready = advance;

  // Stage 0: operand prep, subtract is A + ~B + 1
  logic             vld_p0;
  logic [N-1:0]     a_p0;
  logic [N-1:0]     b_p0;
  logic             cin_p0;
  logic [TAG_W-1:0] tag_p0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     vld_p0 <= 1'b0;
    else if (advance) vld_p0 <= i_valid;
  end

  always_ff @(posedge i_clk) begin
    if (advance) begin
      a_p0   <= i_a;
      b_p0   <= i_sub ? ~i_b : i_b;
      cin_p0 <= i_sub | i_cin;
      tag_p0 <= i_tag;
    end
  end

  gp_t [N-1:0] gp_init;
  always_comb begin
    for (int i = 1; i < N; i++) begin
      gp_init[i].g = a_p0[i] & b_p0[i];
      gp_init[i].p = a_p0[i] ^ b_p0[i];
    end
    gp_init[0].g = (a_p0[0] & b_p0[0]) | ((a_p0[0] ^ b_p0[0]) & cin_p0);
    gp_init[0].p = a_p0[0] ^ b_p0[0];
  end

  // Per-stage views: index 0 is stage 0, index s>0 is the register closing group s-1.
  logic [GROUPS-1:0]            stg_vld;
  logic [GROUPS-1:0]            stg_cin;
  logic [GROUPS-1:0][N-1:0]     stg_pbit;
  logic [GROUPS-1:0][TAG_W-1:0] stg_tag;
  gp_t  [GROUPS-1:0][N-1:0]     stg_gp;

  assign stg_vld[0]  = vld_p0;
  assign stg_cin[0]  = cin_p0;
  assign stg_pbit[0] = a_p0 ^ b_p0;
  assign stg_tag[0]  = tag_p0;
  assign stg_gp[0]   = gp_init;

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    gp_t [N-1:0] gp_in;
    gp_t [N-1:0] gp_out;
    if (k % PIPE_EVERY == 0) begin : g_head
      assign gp_in = stg_gp[k / PIPE_EVERY];
    end else begin : g_body
      assign gp_in = g_level[k-1].gp_out;
    end
    math_kogge_stone_prefix_level #(
      .N    (N),
      .DIST (1 << k)
    ) u_level (
      .gp      (gp_in),
      .gp_next (gp_out)
    );
  end

  // Group boundary registers
  for (genvar s = 1; s < GROUPS; s++) begin : g_stage
    logic             vld_p;
    logic             cin_p;
    logic [N-1:0]     pbit_p;
    logic [TAG_W-1:0] tag_p;
    gp_t  [N-1:0]     gp_p;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     vld_p <= 1'b0;
      else if (advance) vld_p <= stg_vld[s-1];
    end

    always_ff @(posedge i_clk) begin
      if (advance) begin
        gp_p   <= g_level[s*PIPE_EVERY-1].gp_out;
        cin_p  <= stg_cin[s-1];
        pbit_p <= stg_pbit[s-1];
        tag_p  <= stg_tag[s-1];
      end
    end

    assign stg_vld[s]  = vld_p;
    assign stg_cin[s]  = cin_p;
    assign stg_pbit[s] = pbit_p;
    assign stg_tag[s]  = tag_p;
    assign stg_gp[s]   = gp_p;
  end

  // Output stage: final prefix generate bits are the carries into bits 1..N
  logic [N-1:0] g_final;
  logic [N-1:0] p_final_unused;

  for (genvar i = 0; i < N; i++) begin : g_final_bit
    if (LEVELS == 0) begin : g_no_prefix
      assign g_final[i]        = stg_gp[0][i].g;
      assign p_final_unused[i] = stg_gp[0][i].p;
    end else begin : g_prefix
      assign g_final[i]        = g_level[LEVELS-1].gp_out[i].g;
      assign p_final_unused[i] = g_level[LEVELS-1].gp_out[i].p;
    end
  end

  logic [N:0]   carry;
  logic [N-1:0] sum_d;
  assign carry = {g_final, stg_cin[LAST]};
  assign sum_d = stg_pbit[LAST] ^ carry[N-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_sum      <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
      o_tag      <= '0;
    end else if (advance) begin
      o_valid    <= stg_vld[LAST];
      o_sum      <= sum_d;
      o_carry    <= carry[N];
      o_overflow <= carry[N] ^ carry[N-1];
      o_tag      <= stg_tag[LAST];
    end
  end

  assign o_busy = (|stg_vld) | o_valid;

endmodule

// File: tb/tb_math_adder_kogge_stone_pipe.sv
// Self-checking bench: directed vectors, backpressure, mid-stream reset, random traffic.
module tb_math_adder_kogge_stone_pipe;

  localparam int N      = 32;
  localparam int PE     = 2;
  localparam int TW     = 4;
  localparam int TB_GRP = (($clog2(N) + PE - 1) / PE) < 1 ? 1 : (($clog2(N) + PE - 1) / PE);
  localparam int LAT    = 1 + TB_GRP;
  localparam int NOPS   = 4000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, o_ready, i_cin, i_sub, o_valid, i_ready;
  logic          o_carry, o_overflow, o_busy;
  logic [N-1:0]  i_a, i_b, o_sum;
  logic [TW-1:0] i_tag, o_tag;

  always #5 clk = ~clk;

  math_adder_kogge_stone_pipe #(.N(N), .PIPE_EVERY(PE), .TAG_W(TW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_cin(i_cin), .i_sub(i_sub), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_carry(o_carry),
    .o_overflow(o_overflow), .o_tag(o_tag), .o_busy(o_busy)
  );

  typedef struct {
    logic [N-1:0]  a, b;
    logic          cin, sub;
    logic [TW-1:0] tag;
    logic [N-1:0]  sum;
    logic          carry, ovf;
  } vec_t;

  typedef struct {
    logic [N-1:0]  sum;
    logic          carry, ovf;
    logic [TW-1:0] tag;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[7];
  exp_t bp_exp[6];
  exp_t sb[$];
  exp_t e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain (N+1)-bit addition, overflow by the operand/result sign rule.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic cin, input logic sub, input logic [TW-1:0] tag);
    logic [N-1:0] bo;
    logic [N:0]   full;
    bo         = sub ? ~b : b;
    full       = {1'b0, a} + {1'b0, bo} + {{N{1'b0}}, (sub ? 1'b1 : cin)};
    model.sum   = full[N-1:0];
    model.carry = full[N];
    model.ovf   = (a[N-1] == bo[N-1]) && (full[N-1] != a[N-1]);
    model.tag   = tag;
  endfunction

  function automatic logic [N-1:0] rand_word();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(N-1){1'b1}}};
      3:       return {1'b1, {(N-1){1'b0}}};
      default: return N'($urandom);
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    @(negedge clk);
    i_a = v.a; i_b = v.b; i_cin = v.cin; i_sub = v.sub; i_tag = v.tag;
    i_valid = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    cyc = 1;
    while (!o_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("vec%0d_latency", idx), cyc, LAT);
    check($sformatf("vec%0d_sum", idx), o_sum, v.sum);
    check($sformatf("vec%0d_carry", idx), o_carry, v.carry);
    check($sformatf("vec%0d_overflow", idx), o_overflow, v.ovf);
    check($sformatf("vec%0d_tag", idx), o_tag, v.tag);
  endtask

  initial begin
    int sent, got, stall_left, cyc, nsent;
    bit stalled_once, stall_now, pending;
    logic [N-1:0]  snap_sum, ra, rb;
    logic [TW-1:0] snap_tag, rtag;
    logic          rcin, rsub;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd3, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd1, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0, 4'd2, 32'h0000_0010, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 4'd4, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'd5, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 4'd15, 32'h0000_0000, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd9, 32'h0000_0000, 1'b1, 1'b0};

    i_valid = 1'b0; i_ready = 1'b1; i_a = '0; i_b = '0; i_cin = 1'b0; i_sub = 1'b0; i_tag = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ready", o_ready, 1);
    check("rst_sum", o_sum, 0);
    check("rst_carry", o_carry, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_tag", o_tag, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Backpressure: six back-to-back ops, three-cycle stall once results start
    for (int k = 0; k < 6; k++)
      bp_exp[k] = model(32'h1234_5678 * (k + 1), 32'h0F0F_0F0F << k, 1'b0, 1'b0, TW'(k));
    sent = 0; got = 0; stall_left = 0; stalled_once = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(negedge clk);
      if (o_valid && !stalled_once) begin
        stalled_once = 1; stall_left = 3; snap_sum = o_sum; snap_tag = o_tag;
      end
      stall_now = (stall_left > 0);
      i_ready = !stall_now;
      if (sent < 6) begin
        i_valid = 1'b1; i_a = 32'h1234_5678 * (sent + 1); i_b = 32'h0F0F_0F0F << sent;
        i_cin = 1'b0; i_sub = 1'b0; i_tag = TW'(sent);
      end else i_valid = 1'b0;
      #1;
      if (stall_now) begin
        check("bp_ready_low", o_ready, 0);
        check("bp_sum_hold", o_sum, snap_sum);
        check("bp_tag_hold", o_tag, snap_tag);
        stall_left--;
      end else if (stalled_once) check("bp_stream_valid", o_valid, 1);
      if (i_valid && o_ready) sent++;
      if (o_valid && i_ready) begin
        check("bp_order_tag", o_tag, TW'(got));
        check("bp_sum", o_sum, bp_exp[got].sum);
        got++;
      end
    end
    check("bp_all_results", got, 6);
    i_valid = 1'b0;
    @(negedge clk);
    check("bp_no_duplicate", o_valid, 0);

    // Reset mid-stream with operations in flight
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_a = 32'h1000 + k; i_b = 32'h22; i_cin = 1'b0; i_sub = 1'b0; i_tag = TW'(k + 1);
      @(negedge clk);
    end
    i_valid = 1'b0;
    check("rst_mid_pre_valid", o_valid, 1);
    check("rst_mid_pre_busy", o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", o_valid, 0);
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_sum", o_sum, 0);
    check("rst_mid_tag", o_tag, 0);
    check("rst_mid_ready", o_ready, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("rst_idle_valid", o_valid, 0);
      check("rst_idle_busy", o_busy, 0);
    end

    // Random traffic with random valid/ready against the scoreboard
    sb.delete(); pending = 0; nsent = 0; cyc = 0;
    ra = '0; rb = '0; rcin = 1'b0; rsub = 1'b0; rtag = '0;
    while ((nsent < NOPS || sb.size() > 0) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (!pending && nsent < NOPS && $urandom_range(3) != 0) begin
        ra = rand_word(); rb = rand_word();
        rcin = 1'($urandom_range(1)); rsub = 1'($urandom_range(1)); rtag = TW'($urandom_range(15));
        pending = 1;
      end
      i_valid = pending; i_a = ra; i_b = rb; i_cin = rcin; i_sub = rsub; i_tag = rtag;
      i_ready = ($urandom_range(9) < 7);
      #1;
      if (o_valid && i_ready) begin
        if (sb.size() == 0) check("rnd_spurious_valid", o_valid, 0);
        else begin
          e = sb.pop_front();
          check("rnd_sum", o_sum, e.sum);
          check("rnd_carry", o_carry, e.carry);
          check("rnd_overflow", o_overflow, e.ovf);
          check("rnd_tag", o_tag, e.tag);
        end
      end
      if (i_valid && o_ready) begin
        sb.push_back(model(ra, rb, rcin, rsub, rtag));
        pending = 0;
        nsent++;
      end
    end
    check("rnd_drained", (sb.size() == 0) && (nsent == NOPS), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
